tdm_demux_1x8: RTL and testbench
================================

Name: tdm_demux_1x8

Overview:
- Receive-side counterpart of the team's 8-to-1 select tree: one serial lane carries 8 time-multiplexed channel slots; this block routes each slot back to its own channel register.
- Slot 0 maps to channel 0, in the same order as mux select value 0 picks input 0.
- Collects a full 8-slot frame in a shadow bank, then publishes it atomically on a parallel output with a valid pulse.
- Sits at the far end of a TDM link, between the link and per-channel consumers.

Parameters:
- WIDTH, 1, bits per channel slot (1..32)
- CHANNELS, 8, number of slots per frame; fixed at 8 in this revision, taken from the package
- SEL_W, 3, slot index width; equals clog2(CHANNELS)

Ports:
- clk  input  1  single clock for the whole block; all logic on the rising edge
- rst  input  1  synchronous, active-high reset
- din  input  WIDTH  serial slot data
- din_valid  input  1  din carries a slot this cycle
- frame_start  input  1  qualifies din as slot 0 of a new frame; meaningful only while din_valid=1
- dout  output  CHANNELS*WIDTH  last complete frame; channel k at dout[k*WIDTH +: WIDTH]
- dout_valid  output  1  one-cycle pulse: dout has just been updated
- frame_err  output  1  one-cycle pulse: partial frame discarded by resync
- busy  output  1  high while a frame is partially collected
- slot  output  SEL_W  index of the next slot expected

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset: dout=0, dout_valid=0, frame_err=0, busy=0, slot=0, shadow bank=0, state=IDLE.
- Reset asserted mid-frame discards the partial frame. No output pulse is produced for it.
- FSM has two states, IDLE and COLLECT. busy is high exactly when state=COLLECT.
- IDLE, din_valid=1 and frame_start=1: write shadow[0]<=din, slot<=1, go to COLLECT.
- IDLE, din_valid=1 and frame_start=0: word is dropped (sync hunting). No error is flagged.
- COLLECT, din_valid=1 and frame_start=0: write shadow[slot]<=din, slot<=slot+1.
- COLLECT, din_valid=1, frame_start=0 and slot==7 (frame completes):
  - on the same edge, dout<={din, shadow[6:0]};
  - dout_valid=1 for exactly the following cycle;
  - slot wraps to 0 and state returns to IDLE.
- Back-to-back frames need no bubble: IDLE accepts frame_start on the very next cycle.
- COLLECT, din_valid=1 and frame_start=1 (resync):
  - frame_err=1 for the next cycle;
  - partial frame discarded; shadow[0]<=din, slot<=1, remain in COLLECT;
  - dout is unchanged and no dout_valid is produced for the discarded frame.
- din_valid=0: no state change, and slot holds. frame_start is ignored.
- Latency: from acceptance of slot 7, dout and dout_valid are updated 1 cycle later.
- dout holds its value between frames. dout_valid and frame_err are never high in the same cycle.
- Shadow writes use one-hot write enables decoded from slot. Unused shadow entries keep their prior contents; this is unobservable, since dout only loads on frame completion.

Decomposition:
- Package tdm_pkg holds: CHANNELS=8, SEL_W=3, the state enum {IDLE, COLLECT}, and a LAST_SLOT constant (=7).
- Sub-module dec_3x8: combinational 3-to-8 one-hot decoder with enable. It produces the shadow write enables from slot and the din_valid & ~resync condition.

Test Plan (WIDTH=1 unless stated):
- Reset then one frame, slots 1,0,1,1,0,0,1,0 on consecutive cycles with frame_start on the first: dout=8'h4D and one dout_valid pulse, one cycle after the 8th slot; busy low afterwards.
- Same frame with din_valid low on alternate cycles: identical dout=8'h4D. slot holds during gaps. dout_valid arrives one cycle after the 8th valid slot.
- Back-to-back frames 8'h4D then 8'hB2 with no idle cycle: two dout_valid pulses exactly 8 cycles apart; dout shows 4D then B2.
- After a 4D frame, a new frame restarts with frame_start on its 5th slot, then 8 good slots of 8'hB2: frame_err pulses once; dout stays 4D until the B2 frame completes, with no extra dout_valid.
- rst asserted after 3 slots of a frame: next cycle all outputs are 0 and slot=0. Subsequent din_valid without frame_start is ignored until the next frame_start.
- WIDTH=4, frame of slots 0x0..0x7: dout=32'h76543210 with one dout_valid pulse; frame_err stays 0 throughout.

Source files
------------

// File: rtl/tdm_pkg.sv
// Shared constants and types for the 1-to-8 TDM demultiplexer.
package tdm_pkg;

  localparam int CHANNELS = 8;
  localparam int SEL_W    = 3;

  localparam logic [SEL_W-1:0] LAST_SLOT = 3'd7;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_e;

endpackage

// File: rtl/dec_3x8.sv
// 3-to-8 one-hot decoder with enable; all outputs low when disabled.
module dec_3x8 (
  input  logic       en,
  input  logic [2:0] sel,
  output logic [7:0] onehot
);

  // one-hot decode of sel, gated by en
  always_comb begin
    onehot = 8'h00;
    if (en) begin
      onehot = 8'h01 << sel;
    end else begin
      onehot = 8'h00;
    end
  end

endmodule

// File: rtl/tdm_demux_1x8.sv
// Receive-side TDM demultiplexer: gathers 8 serial slots into a shadow bank
// and publishes the complete frame atomically with a one-cycle valid pulse.
module tdm_demux_1x8
  import tdm_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WIDTH-1:0]          din,
  input  logic                      din_valid,
  input  logic                      frame_start,
  output logic [CHANNELS*WIDTH-1:0] dout,
  output logic                      dout_valid,
  output logic                      frame_err,
  output logic                      busy,
  output logic [SEL_W-1:0]          slot
);

  state_e                    state_q, state_d;
  logic [SEL_W-1:0]          slot_q, slot_d;
  logic [WIDTH-1:0]          shadow_q [CHANNELS];
  logic [WIDTH-1:0]          shadow_d [CHANNELS];
  logic [CHANNELS*WIDTH-1:0] dout_q, dout_d;
  logic                      dout_valid_q, dout_valid_d;
  logic                      frame_err_q, frame_err_d;
  logic                      resync_s;
  logic                      wr_en_s;
  logic [CHANNELS-1:0]       wr_sel_s;

  // A frame_start mid-collection restarts at slot 0; in IDLE slot_q is already 0,
  // so the decoder covers the normal start, and resync writes entry 0 directly.
  assign resync_s = (state_q == COLLECT) && din_valid && frame_start;
  assign wr_en_s  = din_valid && !resync_s && ((state_q == COLLECT) || frame_start);

  dec_3x8 u_dec (
    .en     (wr_en_s),
    .sel    (slot_q),
    .onehot (wr_sel_s)
  );

  // next-state, shadow write and frame publish logic
  always_comb begin
    state_d      = state_q;
    slot_d       = slot_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (wr_sel_s[k] || (resync_s && (k == 0))) begin
        shadow_d[k] = din;
      end else begin
        shadow_d[k] = shadow_q[k];
      end
    end

    case (state_q)
      IDLE: begin
        if (din_valid && frame_start) begin
          slot_d  = 3'd1;
          state_d = COLLECT;
        end else begin
          state_d = IDLE;
        end
      end
      COLLECT: begin
        if (din_valid) begin
          if (frame_start) begin
            frame_err_d = 1'b1;
            slot_d      = 3'd1;
          end else if (slot_q == LAST_SLOT) begin
            for (int k = 0; k < CHANNELS - 1; k++) begin
              dout_d[k*WIDTH +: WIDTH] = shadow_q[k];
            end
            dout_d[(CHANNELS-1)*WIDTH +: WIDTH] = din;
            dout_valid_d = 1'b1;
            slot_d       = 3'd0;
            state_d      = IDLE;
          end else begin
            slot_d = slot_q + 3'd1;
          end
        end else begin
          slot_d = slot_q;
        end
      end
      default: begin
        state_d = IDLE;
        slot_d  = 3'd0;
      end
    endcase
  end

  // state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      slot_q       <= 3'd0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      for (int k = 0; k < CHANNELS; k++) begin
        shadow_q[k] <= '0;
      end
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      frame_err_q  <= frame_err_d;
      for (int k = 0; k < CHANNELS; k++) begin
        shadow_q[k] <= shadow_d[k];
      end
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign frame_err  = frame_err_q;
  assign busy       = (state_q == COLLECT);
  assign slot       = slot_q;

endmodule

// File: tb/tb_tdm_demux_1x8.sv
// Self-checking bench for tdm_demux_1x8: scoreboard of expected frames plus
// per-scenario inline checks, at WIDTH=1 and WIDTH=4.
module tb_tdm_demux_1x8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        din = 1'b0;
  logic        din_valid = 1'b0;
  logic        frame_start = 1'b0;
  logic [7:0]  dout;
  logic        dout_valid;
  logic        frame_err;
  logic        busy;
  logic [2:0]  slot;

  logic [3:0]  din4 = 4'h0;
  logic        din_valid4 = 1'b0;
  logic        frame_start4 = 1'b0;
  logic [31:0] dout4;
  logic        dout_valid4;
  logic        frame_err4;
  logic        busy4;
  logic [2:0]  slot4;

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc_cnt = 0;
  int          err_cnt = 0;
  int          err4_cnt = 0;
  int          valid4_cnt = 0;
  logic [7:0]  exp_q [$];

  always #5 clk = ~clk;

  tdm_demux_1x8 #(.WIDTH(1)) u_dut (
    .clk         (clk),
    .rst         (rst),
    .din         (din),
    .din_valid   (din_valid),
    .frame_start (frame_start),
    .dout        (dout),
    .dout_valid  (dout_valid),
    .frame_err   (frame_err),
    .busy        (busy),
    .slot        (slot)
  );

  tdm_demux_1x8 #(.WIDTH(4)) u_dut4 (
    .clk         (clk),
    .rst         (rst),
    .din         (din4),
    .din_valid   (din_valid4),
    .frame_start (frame_start4),
    .dout        (dout4),
    .dout_valid  (dout_valid4),
    .frame_err   (frame_err4),
    .busy        (busy4),
    .slot        (slot4)
  );

  // Advance one clock, sample 1 time unit after the edge, and retire any frame
  // the DUT publishes against the scoreboard.
  task automatic step();
    logic [7:0] e;
    @(posedge clk);
    #1;
    cyc_cnt++;
    if (frame_err)   err_cnt++;
    if (frame_err4)  err4_cnt++;
    if (dout_valid4) valid4_cnt++;
    if (dout_valid) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL sb_unexpected_valid: dout=%h with no frame expected (cycle %0d)", dout, cyc_cnt);
      end else begin
        e = exp_q.pop_front();
        if (dout !== e) begin
          miscompares++;
          $display("FAIL sb_dout: got %h expected %h (cycle %0d)", dout, e, cyc_cnt);
        end
      end
    end
    if (dout_valid && frame_err) begin
      vectors++;
      miscompares++;
      $display("FAIL valid_err_overlap: dout_valid=%b frame_err=%b expected not both 1", dout_valid, frame_err);
    end
  endtask

  task automatic drive(input logic d, input logic v, input logic fs);
    din         = d;
    din_valid   = v;
    frame_start = fs;
    step();
    din_valid   = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] f);
    for (int k = 0; k < 8; k++) begin
      if (k == 7) exp_q.push_back(f);
      drive(f[k], 1'b1, (k == 0));
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    vectors += 5;
    if (dout !== 8'h00)      begin miscompares++; $display("FAIL reset_dout: got %h expected 00", dout); end
    if (dout_valid !== 1'b0) begin miscompares++; $display("FAIL reset_dout_valid: got %b expected 0", dout_valid); end
    if (frame_err !== 1'b0)  begin miscompares++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
    if (busy !== 1'b0)       begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
    if (slot !== 3'd0)       begin miscompares++; $display("FAIL reset_slot: got %0d expected 0", slot); end
    rst = 1'b0;
  endtask

  task automatic test_single();
    send_frame(8'h4D);
    vectors += 3;
    if (dout_valid !== 1'b1) begin miscompares++; $display("FAIL single_valid: got %b expected 1", dout_valid); end
    if (dout !== 8'h4D)      begin miscompares++; $display("FAIL single_dout: got %h expected 4d", dout); end
    if (busy !== 1'b0)       begin miscompares++; $display("FAIL single_busy_done: got %b expected 0", busy); end
    drive(1'b0, 1'b0, 1'b0);
    vectors += 3;
    if (dout_valid !== 1'b0) begin miscompares++; $display("FAIL single_valid_pulse: got %b expected 0", dout_valid); end
    if (busy !== 1'b0)       begin miscompares++; $display("FAIL single_busy_after: got %b expected 0", busy); end
    if (dout !== 8'h4D)      begin miscompares++; $display("FAIL single_dout_hold: got %h expected 4d", dout); end
  endtask

  task automatic test_back_to_back();
    int t1;
    int t2;
    send_frame(8'h4D);
    t1 = cyc_cnt;
    vectors += 2;
    if (dout_valid !== 1'b1) begin miscompares++; $display("FAIL b2b_valid1: got %b expected 1", dout_valid); end
    if (dout !== 8'h4D)      begin miscompares++; $display("FAIL b2b_dout1: got %h expected 4d", dout); end
    send_frame(8'hB2);
    t2 = cyc_cnt;
    vectors += 3;
    if (dout_valid !== 1'b1) begin miscompares++; $display("FAIL b2b_valid2: got %b expected 1", dout_valid); end
    if (dout !== 8'hB2)      begin miscompares++; $display("FAIL b2b_dout2: got %h expected b2", dout); end
    if ((t2 - t1) !== 8)     begin miscompares++; $display("FAIL b2b_spacing: got %0d cycles expected 8", t2 - t1); end
  endtask

  task automatic test_gaps();
    logic [7:0] f;
    f = 8'h4D;
    for (int k = 0; k < 8; k++) begin
      if (k == 7) exp_q.push_back(f);
      drive(f[k], 1'b1, (k == 0));
      if (k < 7) begin
        vectors++;
        if (slot !== 3'(k + 1)) begin miscompares++; $display("FAIL gaps_slot_adv: got %0d expected %0d", slot, k + 1); end
        drive(1'b1, 1'b0, 1'b1);
        vectors += 2;
        if (slot !== 3'(k + 1)) begin miscompares++; $display("FAIL gaps_slot_hold: got %0d expected %0d", slot, k + 1); end
        if (dout_valid !== 1'b0) begin miscompares++; $display("FAIL gaps_early_valid: got %b expected 0", dout_valid); end
      end
    end
    vectors += 3;
    if (dout_valid !== 1'b1) begin miscompares++; $display("FAIL gaps_valid: got %b expected 1", dout_valid); end
    if (dout !== 8'h4D)      begin miscompares++; $display("FAIL gaps_dout: got %h expected 4d", dout); end
    if (busy !== 1'b0)       begin miscompares++; $display("FAIL gaps_busy: got %b expected 0", busy); end
  endtask

  task automatic test_resync();
    int e0;
    logic [7:0] f;
    f  = 8'hB2;
    e0 = err_cnt;
    for (int k = 0; k < 4; k++) drive(1'b1, 1'b1, (k == 0));
    vectors += 2;
    if (busy !== 1'b1) begin miscompares++; $display("FAIL resync_busy_partial: got %b expected 1", busy); end
    if (slot !== 3'd4) begin miscompares++; $display("FAIL resync_slot_partial: got %0d expected 4", slot); end
    for (int k = 0; k < 8; k++) begin
      if (k == 7) exp_q.push_back(f);
      drive(f[k], 1'b1, (k == 0));
      if (k == 0) begin
        vectors += 4;
        if (frame_err !== 1'b1)  begin miscompares++; $display("FAIL resync_err: got %b expected 1", frame_err); end
        if (dout_valid !== 1'b0) begin miscompares++; $display("FAIL resync_no_valid: got %b expected 0", dout_valid); end
        if (slot !== 3'd1)       begin miscompares++; $display("FAIL resync_slot: got %0d expected 1", slot); end
        if (busy !== 1'b1)       begin miscompares++; $display("FAIL resync_busy: got %b expected 1", busy); end
      end
      if (k < 7) begin
        vectors++;
        if (dout !== 8'h4D) begin miscompares++; $display("FAIL resync_dout_hold: got %h expected 4d", dout); end
      end
    end
    vectors += 3;
    if (dout !== 8'hB2)      begin miscompares++; $display("FAIL resync_dout_new: got %h expected b2", dout); end
    if (dout_valid !== 1'b1) begin miscompares++; $display("FAIL resync_valid_new: got %b expected 1", dout_valid); end
    if ((err_cnt - e0) !== 1) begin miscompares++; $display("FAIL resync_err_count: got %0d expected 1", err_cnt - e0); end
  endtask

  task automatic test_rst_mid();
    for (int k = 0; k < 3; k++) drive(1'b1, 1'b1, (k == 0));
    rst = 1'b1;
    step();
    rst = 1'b0;
    vectors += 5;
    if (dout !== 8'h00)      begin miscompares++; $display("FAIL rstmid_dout: got %h expected 00", dout); end
    if (dout_valid !== 1'b0) begin miscompares++; $display("FAIL rstmid_valid: got %b expected 0", dout_valid); end
    if (frame_err !== 1'b0)  begin miscompares++; $display("FAIL rstmid_err: got %b expected 0", frame_err); end
    if (busy !== 1'b0)       begin miscompares++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    if (slot !== 3'd0)       begin miscompares++; $display("FAIL rstmid_slot: got %0d expected 0", slot); end
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b1, 1'b0);
      vectors += 3;
      if (slot !== 3'd0)  begin miscompares++; $display("FAIL hunt_slot: got %0d expected 0", slot); end
      if (busy !== 1'b0)  begin miscompares++; $display("FAIL hunt_busy: got %b expected 0", busy); end
      if (dout !== 8'h00) begin miscompares++; $display("FAIL hunt_dout: got %h expected 00", dout); end
    end
    send_frame(8'hB2);
    vectors += 2;
    if (dout !== 8'hB2)      begin miscompares++; $display("FAIL rstmid_next_dout: got %h expected b2", dout); end
    if (dout_valid !== 1'b1) begin miscompares++; $display("FAIL rstmid_next_valid: got %b expected 1", dout_valid); end
  endtask

  task automatic test_width4();
    int v0;
    v0 = valid4_cnt;
    for (int k = 0; k < 8; k++) begin
      din4         = 4'(k);
      din_valid4   = 1'b1;
      frame_start4 = (k == 0);
      step();
      din_valid4   = 1'b0;
      frame_start4 = 1'b0;
    end
    vectors += 2;
    if (dout4 !== 32'h7654_3210) begin miscompares++; $display("FAIL w4_dout: got %h expected 76543210", dout4); end
    if (dout_valid4 !== 1'b1)    begin miscompares++; $display("FAIL w4_valid: got %b expected 1", dout_valid4); end
    step();
    vectors += 3;
    if (dout_valid4 !== 1'b0)       begin miscompares++; $display("FAIL w4_valid_pulse: got %b expected 0", dout_valid4); end
    if ((valid4_cnt - v0) !== 1)    begin miscompares++; $display("FAIL w4_valid_count: got %0d expected 1", valid4_cnt - v0); end
    if (err4_cnt !== 0)             begin miscompares++; $display("FAIL w4_frame_err: got %0d pulses expected 0", err4_cnt); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_gaps();
    test_resync();
    test_rst_mid();
    test_width4();
    drive(1'b0, 1'b0, 1'b0);
    vectors++;
    if (exp_q.size() !== 0) begin
      miscompares++;
      $display("FAIL sb_leftover: got %0d frames pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
